pc_rx_packet_dispatcher: RTL and testbench

Sequences reads from the PC_RX word FIFO (32-bit words, normal-mode read: data valid one cycle after read request) and routes each packet's payload to one of two downstream consumers. Each packet is a header word followed by N payload words. The block pops the header, checks the sync byte, and forwards payload words over a valid/ready handshake to destination A or B. It aborts a packet whose payload stops arriving. It sits between the PC_RX FIFO read side and the data-manager consumers.

---
 rtl/pc_rx_packet_dispatcher.sv | 134 +++++++++++++
 tb/tb_pc_rx_packet_dispatcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_rx_packet_dispatcher.sv
// rtl/pc_rx_packet_dispatcher.sv - pops PC_RX FIFO packets, checks sync, routes payload to A or B
module pc_rx_packet_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_fifo_word,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd,
    output logic [31:0] o_word,
    output logic        o_valid_a,
    input  logic        i_ready_a,
    output logic        o_valid_b,
    input  logic        i_ready_b,
    output logic        o_pkt_start,
    output logic        o_pkt_done,
    output logic        o_err_sync,
    output logic        o_err_timeout,
    output logic        o_busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR_CAP,
        PAY_REQ,
        PAY_CAP,
        PAY_OUT,
        DONE
    } state_t;

    state_t          state;
    logic            dest;
    logic [15:0]     remaining;
    logic [TW-1:0]   tmo_cnt;
    logic            zero_len;
    logic            handshake;
    logic            unused_hdr_bits;

    assign unused_hdr_bits = ^i_fifo_word[23:17];

    // Gated by reset so a held reset never pops words out of the FIFO.
    assign o_fifo_rd = i_reset_n && !i_fifo_empty && ((state == IDLE) || (state == PAY_REQ));
    assign handshake = dest ? (o_valid_b && i_ready_b) : (o_valid_a && i_ready_a);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            dest          <= 1'b0;
            remaining     <= 16'd0;
            tmo_cnt       <= '0;
            zero_len      <= 1'b0;
            o_word        <= 32'd0;
            o_valid_a     <= 1'b0;
            o_valid_b     <= 1'b0;
            o_pkt_start   <= 1'b0;
            o_pkt_done    <= 1'b0;
            o_err_sync    <= 1'b0;
            o_err_timeout <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_pkt_start   <= 1'b0;
            o_pkt_done    <= 1'b0;
            o_err_sync    <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_fifo_empty) begin
                        state  <= HDR_CAP;
                        o_busy <= 1'b1;
                    end
                end
                HDR_CAP: begin
                    if (i_fifo_word[31:24] != SYNC_BYTE) begin
                        o_err_sync <= 1'b1;
                        state      <= IDLE;
                        o_busy     <= 1'b0;
                    end else begin
                        o_pkt_start <= 1'b1;
                        dest        <= i_fifo_word[16];
                        remaining   <= i_fifo_word[15:0];
                        zero_len    <= (i_fifo_word[15:0] == 16'd0);
                        state       <= (i_fifo_word[15:0] == 16'd0) ? DONE : PAY_REQ;
                    end
                end
                PAY_REQ: begin
                    if (!i_fifo_empty) begin
                        tmo_cnt <= '0;
                        state   <= PAY_CAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt       <= '0;
                        o_err_timeout <= 1'b1;
                        state         <= IDLE;
                        o_busy        <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                PAY_CAP: begin
                    o_word    <= i_fifo_word;
                    o_valid_a <= !dest;
                    o_valid_b <= dest;
                    state     <= PAY_OUT;
                end
                PAY_OUT: begin
                    if (handshake) begin
                        o_valid_a <= 1'b0;
                        o_valid_b <= 1'b0;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            o_pkt_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= PAY_REQ;
                        end
                    end
                end
                DONE: begin
                    // Empty packets arrive here with o_pkt_start still high, so their done follows one cycle later.
                    o_pkt_done <= zero_len;
                    zero_len   <= 1'b0;
                    state      <= IDLE;
                    o_busy     <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_rx_packet_dispatcher.sv
// tb/tb_pc_rx_packet_dispatcher.sv - self-checking bench for pc_rx_packet_dispatcher
module tb_pc_rx_packet_dispatcher;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_fifo_word;
    logic        i_fifo_empty;
    logic        o_fifo_rd;
    logic [31:0] o_word;
    logic        o_valid_a, i_ready_a, o_valid_b, i_ready_b;
    logic        o_pkt_start, o_pkt_done, o_err_sync, o_err_timeout, o_busy;

    always #5 clk = ~clk;

    pc_rx_packet_dispatcher #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .i_clock(clk), .i_reset_n(i_reset_n),
        .i_fifo_word(i_fifo_word), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd),
        .o_word(o_word), .o_valid_a(o_valid_a), .i_ready_a(i_ready_a),
        .o_valid_b(o_valid_b), .i_ready_b(i_ready_b),
        .o_pkt_start(o_pkt_start), .o_pkt_done(o_pkt_done), .o_err_sync(o_err_sync),
        .o_err_timeout(o_err_timeout), .o_busy(o_busy)
    );

    typedef struct {
        logic [31:0] hdr;
        int exp_start; int exp_done; int exp_sync;
        int exp_a; int exp_b; int exp_rd;
        int exp_lat; int exp_gap;
    } vec_t;

    int n_checks = 0, n_fail = 0, cyc = 0;
    logic [31:0] q[$], exp_a[$], exp_b[$], got_a[$], got_b[$];
    int n_rd, n_start, n_done, n_sync, n_tmo, n_stall_b;
    int first_rd, start_cyc, done_cyc, sync_cyc, tmo_cyc, hs_cyc;
    bit tmo_busy, any_valid;
    int viol_rd = 0, viol_both = 0, viol_pulse = 0, viol_hold = 0;
    bit prev_stall = 0;
    logic [31:0] prev_word = 0;
    logic [1:0]  prev_v = 0;
    int rdy_mode = 0, stall_left = 0, gap_run = 0;
    bit gap_en = 0, gap_now = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qdiff(input logic [31:0] a[$], input logic [31:0] b[$]);
        int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        i_fifo_empty = gap_now || (q.size() == 0);
    endtask

    task automatic clear_run();
        n_rd = 0; n_start = 0; n_done = 0; n_sync = 0; n_tmo = 0; n_stall_b = 0;
        first_rd = -1; start_cyc = -1; done_cyc = -1; sync_cyc = -1; tmo_cyc = -1; hs_cyc = -1;
        tmo_busy = 1; any_valid = 0;
        exp_a.delete(); exp_b.delete(); got_a.delete(); got_b.delete();
    endtask

    // One clock: observe at the falling edge, then model the FIFO and drive inputs after the rising edge.
    task automatic step();
        bit rd_seen;
        @(negedge clk);
        rd_seen = o_fifo_rd;
        if (o_fifo_rd && i_fifo_empty) viol_rd++;
        if (o_fifo_rd) begin n_rd++; if (first_rd < 0) first_rd = cyc; end
        if (o_valid_a && o_valid_b) viol_both++;
        if (int'(o_pkt_start) + int'(o_pkt_done) + int'(o_err_sync) + int'(o_err_timeout) > 1) viol_pulse++;
        if (prev_stall && (o_word !== prev_word || {o_valid_a, o_valid_b} !== prev_v)) viol_hold++;
        prev_stall = (o_valid_a && !i_ready_a) || (o_valid_b && !i_ready_b);
        prev_word = o_word;
        prev_v = {o_valid_a, o_valid_b};
        if (o_valid_a || o_valid_b) any_valid = 1;
        if (o_valid_b && !i_ready_b) n_stall_b++;
        if (o_valid_a && i_ready_a) begin got_a.push_back(o_word); hs_cyc = cyc; end
        if (o_valid_b && i_ready_b) begin got_b.push_back(o_word); hs_cyc = cyc; end
        if (o_pkt_start) begin n_start++; start_cyc = cyc; end
        if (o_pkt_done) begin n_done++; done_cyc = cyc; end
        if (o_err_sync) begin n_sync++; sync_cyc = cyc; end
        if (o_err_timeout) begin n_tmo++; tmo_cyc = cyc; tmo_busy = o_busy; end
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen && q.size() > 0) i_fifo_word = q.pop_front();
        if (gap_en && gap_run < 3 && $urandom_range(0, 2) == 0) begin
            gap_now = 1; gap_run++;
        end else begin
            gap_now = 0; gap_run = 0;
        end
        i_fifo_empty = gap_now || (q.size() == 0);
        case (rdy_mode)
            0: begin i_ready_a = 1; i_ready_b = 1; end
            1: begin i_ready_a = ($urandom_range(0, 3) != 0); i_ready_b = ($urandom_range(0, 3) != 0); end
            2: begin
                i_ready_a = ~i_ready_a;
                if (o_valid_b && stall_left > 0) begin i_ready_b = 0; stall_left--; end
                else i_ready_b = 1;
            end
            default: begin i_ready_a = 0; i_ready_b = 0; end
        endcase
    endtask

    task automatic run_idle(input int budget);
        int n = 0, quiet = 0;
        while (quiet < 4 && n < budget) begin
            step();
            n++;
            if (!o_busy && q.size() == 0) quiet++; else quiet = 0;
        end
        if (quiet < 4) begin
            n_checks++; n_fail++;
            $display("FAIL run_budget: still busy after %0d cycles", n);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hA500_0003, 1, 1, 0, 3, 0, 4, 11, -1};
        vecs[1] = '{32'hA501_0002, 1, 1, 0, 0, 2, 3,  8, -1};
        vecs[2] = '{32'hA5FE_0001, 1, 1, 0, 1, 0, 2,  5, -1};
        vecs[3] = '{32'hA5FF_0004, 1, 1, 0, 0, 4, 5, 14, -1};
        vecs[4] = '{32'hA500_0000, 1, 1, 0, 0, 0, 1, -1,  1};
        vecs[5] = '{32'hA501_0000, 1, 1, 0, 0, 0, 1, -1,  1};
        vecs[6] = '{32'h5A00_0000, 0, 0, 1, 0, 0, 1, -1, -1};
        vecs[7] = '{32'hA400_0001, 0, 0, 1, 0, 0, 1, -1, -1};

        i_reset_n = 0; i_fifo_word = 0; i_fifo_empty = 1; i_ready_a = 1; i_ready_b = 1;
        repeat (3) @(posedge clk);
        #1 i_fifo_empty = 0;
        #1;
        check("reset_outputs", {o_valid_a, o_valid_b, o_busy, o_pkt_start, o_pkt_done,
                                o_err_sync, o_err_timeout, o_fifo_rd}, 0);
        check("reset_word", o_word, 0);
        i_fifo_empty = 1;
        @(posedge clk);
        #1 i_reset_n = 1;

        for (int i = 0; i < 8; i++) begin
            logic [31:0] h;
            h = vecs[i].hdr;
            clear_run();
            push(h);
            if (h[31:24] == 8'hA5)
                for (int j = 0; j < int'(h[15:0]); j++) begin
                    logic [31:0] w;
                    w = $urandom;
                    push(w);
                    if (h[16]) exp_b.push_back(w); else exp_a.push_back(w);
                end
            run_idle(500);
            check($sformatf("v%0d_start", i), n_start, vecs[i].exp_start);
            check($sformatf("v%0d_done", i), n_done, vecs[i].exp_done);
            check($sformatf("v%0d_sync", i), n_sync, vecs[i].exp_sync);
            check($sformatf("v%0d_cnt_a", i), got_a.size(), vecs[i].exp_a);
            check($sformatf("v%0d_cnt_b", i), got_b.size(), vecs[i].exp_b);
            check($sformatf("v%0d_reads", i), n_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_words", i), qdiff(got_a, exp_a) + qdiff(got_b, exp_b), 0);
            if (vecs[i].exp_lat >= 0) check($sformatf("v%0d_done_lat", i), done_cyc - first_rd, vecs[i].exp_lat);
            if (vecs[i].exp_gap >= 0) check($sformatf("v%0d_start_done_gap", i), done_cyc - start_cyc, vecs[i].exp_gap);
        end

        // Destination B stalled for 5 cycles on its first word while ready_a toggles.
        clear_run();
        rdy_mode = 2; stall_left = 5;
        push(32'hA501_0002);
        exp_b.push_back(32'h1357_9BDF); push(32'h1357_9BDF);
        exp_b.push_back(32'h0246_8ACE); push(32'h0246_8ACE);
        run_idle(500);
        check("stall_cycles", n_stall_b, 5);
        check("stall_hold", viol_hold, 0);
        check("stall_reads", n_rd, 3);
        check("stall_words_b", qdiff(got_b, exp_b), 0);
        check("stall_no_a", got_a.size(), 0);
        check("stall_done", n_done, 1);

        // Bad sync word followed by an empty packet.
        clear_run();
        rdy_mode = 0;
        push(32'h1200_0001);
        push(32'hA500_0000);
        run_idle(500);
        check("seq_sync", n_sync, 1);
        check("seq_start", n_start, 1);
        check("seq_sync_first", sync_cyc < start_cyc, 1);
        check("seq_done_gap", done_cyc - start_cyc, 1);
        check("seq_no_valid", any_valid, 0);
        check("seq_reads", n_rd, 2);

        // Only one of four payload words ever arrives.
        clear_run();
        push(32'hA500_0004);
        exp_a.push_back(32'h0000_CAFE); push(32'h0000_CAFE);
        run_idle(500);
        check("tmo_words", qdiff(got_a, exp_a), 0);
        check("tmo_pulse", n_tmo, 1);
        check("tmo_no_done", n_done, 0);
        check("tmo_latency", tmo_cyc - hs_cyc, TMO + 1);
        check("tmo_busy_low", tmo_busy, 0);

        // Reset while a payload word is stalled in front of destination A.
        clear_run();
        rdy_mode = 3;
        push(32'hA500_0003); push(32'h0000_0011); push(32'h0000_0022); push(32'h0000_0033);
        begin
            int k = 0;
            while (!o_valid_a && k < 50) begin step(); k++; end
        end
        check("rst_pre_valid", o_valid_a, 1);
        check("rst_pre_word", o_word, 32'h11);
        #2 i_reset_n = 0;
        #1;
        check("rst_async_outputs", {o_valid_a, o_valid_b, o_busy, o_pkt_start, o_pkt_done,
                                    o_err_sync, o_err_timeout, o_fifo_rd}, 0);
        check("rst_async_word", o_word, 0);
        prev_stall = 0;
        rdy_mode = 0;
        step(); step();
        i_reset_n = 1;
        clear_run();
        run_idle(500);
        check("rst_leftover_sync", n_sync, 2);
        check("rst_leftover_start", n_start, 0);
        check("rst_leftover_reads", n_rd, 2);

        // Twenty random packets with random FIFO gaps and random downstream readiness.
        clear_run();
        rdy_mode = 1; gap_en = 1;
        begin
            int sum_n = 0;
            for (int p = 0; p < 20; p++) begin
                int n;
                logic d;
                logic [6:0] junk;
                n = $urandom_range(0, 6);
                d = 1'($urandom_range(0, 1));
                junk = 7'($urandom);
                sum_n += n;
                push({8'hA5, junk, d, 16'(n)});
                for (int j = 0; j < n; j++) begin
                    logic [31:0] w;
                    w = $urandom;
                    push(w);
                    if (d) exp_b.push_back(w); else exp_a.push_back(w);
                end
            end
            run_idle(5000);
            check("rnd_start", n_start, 20);
            check("rnd_done", n_done, 20);
            check("rnd_total", got_a.size() + got_b.size(), sum_n);
            check("rnd_words_a", qdiff(got_a, exp_a), 0);
            check("rnd_words_b", qdiff(got_b, exp_b), 0);
            check("rnd_reads", n_rd, 20 + sum_n);
            check("rnd_no_tmo", n_tmo, 0);
        end
        gap_en = 0; rdy_mode = 0;

        check("rd_while_empty", viol_rd, 0);
        check("both_valids", viol_both, 0);
        check("pulse_overlap", viol_pulse, 0);
        check("stall_hold_all", viol_hold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
